a2d_sequencer: RTL and testbench

- Round-robin scheduler for the shared SPI A2D converter.
- Sequences conversions on the left load cell, right load cell, steering pot and battery channels, one channel per trigger.
- Drives the SPI master handshake and holds the latest 12-bit result per channel.
- Holding registers feed the rider-detect/steer-enable logic (lft_ld, rght_ld), the balance controller (steer_pot) and the battery monitor (batt).

---
 rtl/a2d_pkg.sv | 25 ++
 rtl/a2d_sequencer.sv | 108 ++++++++++
 tb/tb_a2d_sequencer.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/a2d_pkg.sv
// Shared types and defaults for the A2D round-robin sequencer.
package a2d_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DEAD = 2'd2,
        READ = 2'd3
    } a2d_state_t;

    // Round-robin position: 0 left, 1 right, 2 steer, 3 battery.
    typedef logic [1:0] rr_idx_t;

    localparam logic [2:0] DEF_CH_LFT   = 3'd0;
    localparam logic [2:0] DEF_CH_RGHT  = 3'd4;
    localparam logic [2:0] DEF_CH_STEER = 3'd5;
    localparam logic [2:0] DEF_CH_BATT  = 3'd6;
    localparam int         DEF_DEAD_CYC = 2;

    // SPI command word: channel number in bits [13:11], everything else zero.
    function automatic logic [15:0] build_cmd(input logic [2:0] chnl);
        return {2'b00, chnl, 11'h000};
    endfunction

endpackage

// File: rtl/a2d_sequencer.sv
// Round-robin conversion scheduler for the shared SPI A2D converter.
//
// state | meaning
// IDLE  | waiting for nxt; nxt fires the first wrt combinationally
// CMD   | first SPI transaction (channel select) in flight, waiting for done
// DEAD  | idle gap between transactions, counting down to the second wrt
// READ  | second SPI transaction in flight; done captures the result
module a2d_sequencer
    import a2d_pkg::*;
#(
    parameter logic [2:0] CH_LFT   = DEF_CH_LFT,
    parameter logic [2:0] CH_RGHT  = DEF_CH_RGHT,
    parameter logic [2:0] CH_STEER = DEF_CH_STEER,
    parameter logic [2:0] CH_BATT  = DEF_CH_BATT,
    parameter int         DEAD_CYC = DEF_DEAD_CYC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        nxt,
    output logic        wrt,
    output logic [15:0] cmd,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] steer_pot,
    output logic [11:0] batt,
    output logic        cnv_cmplt,
    output logic        busy
);

    a2d_state_t state;
    rr_idx_t    idx;
    logic [2:0] dead_cnt;
    logic [2:0] cur_ch;

    // Map the round-robin index to its A2D channel; cmd follows the index,
    // which only moves on capture, so it is stable across both transactions.
    always_comb begin
        cur_ch = CH_BATT;
        case (idx)
            2'd0:    cur_ch = CH_LFT;
            2'd1:    cur_ch = CH_RGHT;
            2'd2:    cur_ch = CH_STEER;
            default: cur_ch = CH_BATT;
        endcase
    end

    assign cmd = build_cmd(cur_ch);

    // wrt is combinational so the first transaction starts in the nxt cycle;
    // IDLE and DEAD are never adjacent, so wrt cannot fire twice in a row.
    assign wrt = ((state == IDLE) && nxt) || ((state == DEAD) && (dead_cnt == 3'd0));

    // Sequencer FSM with dead-time counter, holding registers and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= 2'd0;
            dead_cnt  <= 3'd0;
            lft_ld    <= 12'h000;
            rght_ld   <= 12'h000;
            steer_pot <= 12'h000;
            batt      <= 12'h000;
            cnv_cmplt <= 1'b0;
            busy      <= 1'b0;
        end else begin
            cnv_cmplt <= 1'b0;
            case (state)
                IDLE: begin
                    if (nxt) begin
                        state <= CMD;
                        busy  <= 1'b1;
                    end
                end
                CMD: begin
                    if (done) begin
                        state    <= DEAD;
                        dead_cnt <= 3'(DEAD_CYC - 1);
                    end
                end
                DEAD: begin
                    if (dead_cnt == 3'd0) begin
                        state <= READ;
                    end else begin
                        dead_cnt <= dead_cnt - 3'd1;
                    end
                end
                READ: begin
                    if (done) begin
                        case (idx)
                            2'd0:    lft_ld    <= rd_data[11:0];
                            2'd1:    rght_ld   <= rd_data[11:0];
                            2'd2:    steer_pot <= rd_data[11:0];
                            default: batt      <= rd_data[11:0];
                        endcase
                        idx       <= idx + 2'd1;
                        state     <= IDLE;
                        busy      <= 1'b0;
                        cnv_cmplt <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_a2d_sequencer.sv
// Self-checking bench for a2d_sequencer: a table of conversions plus
// hand-written sequences for back-to-back nxt and mid-transaction reset.
module tb_a2d_sequencer;

    logic        clk;
    logic        rst_n;
    logic        nxt;
    logic        wrt;
    logic [15:0] cmd;
    logic        done;
    logic [15:0] rd_data;
    logic [11:0] lft_ld;
    logic [11:0] rght_ld;
    logic [11:0] steer_pot;
    logic [11:0] batt;
    logic        cnv_cmplt;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    a2d_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .nxt       (nxt),
        .wrt       (wrt),
        .cmd       (cmd),
        .done      (done),
        .rd_data   (rd_data),
        .lft_ld    (lft_ld),
        .rght_ld   (rght_ld),
        .steer_pot (steer_pot),
        .batt      (batt),
        .cnv_cmplt (cnv_cmplt),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [15:0] rd;
        logic [15:0] ecmd;
        logic [11:0] el;
        logic [11:0] er;
        logic [11:0] es;
        logic [11:0] eb;
        bit          spur;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full conversion. Entered 1 time unit after a rising edge.
    // started: first wrt already issued (chained from previous cnv_cmplt cycle).
    // hold: nxt held high throughout; chain: nxt high in the cnv_cmplt cycle.
    // spur: spurious done with rd_data=FFFF in IDLE and in the first DEAD cycle.
    task automatic conv(input logic [15:0] rd, input logic [15:0] ecmd,
                        input logic [11:0] el, input logic [11:0] er,
                        input logic [11:0] es, input logic [11:0] eb,
                        input bit hold, input bit chain, input bit started, input bit spur);
        int n;
        int wrts;
        if (spur && !started) begin
            done = 1'b1;
            rd_data = 16'hFFFF;
            @(negedge clk);
            chk("idle_done_wrt", 16'(wrt), 16'h0);
            tick();
            done = 1'b0;
            rd_data = 16'h0000;
            @(negedge clk);
            chk("idle_done_cmplt", 16'(cnv_cmplt), 16'h0);
            chk("idle_done_busy", 16'(busy), 16'h0);
            tick();
        end
        if (!started) begin
            nxt = 1'b1;
            @(negedge clk);
            chk("first_wrt", 16'(wrt), 16'h1);
            chk("first_cmd", cmd, ecmd);
            tick();
        end
        nxt = hold;
        wrts = 1;
        // CMD phase: SPI master latency of 3 clocks
        repeat (2) begin
            @(negedge clk);
            chk("busy_cmd", 16'(busy), 16'h1);
            if (wrt) wrts++;
            tick();
        end
        done = 1'b1;
        rd_data = rd;
        @(negedge clk);
        chk("cmd_stable", cmd, ecmd);
        if (wrt) wrts++;
        tick();
        done = 1'b0;
        rd_data = 16'h0000;
        if (spur) begin
            done = 1'b1;
            rd_data = 16'hFFFF;
        end
        n = 1;
        while (n <= 20) begin
            @(negedge clk);
            if (wrt) break;
            tick();
            done = 1'b0;
            rd_data = 16'h0000;
            n++;
        end
        chk("dead_gap", 16'(n), 16'd2);
        if (wrt) wrts++;
        chk("second_cmd", cmd, ecmd);
        tick();
        done = 1'b0;
        rd_data = 16'h0000;
        repeat (2) begin
            @(negedge clk);
            if (wrt) wrts++;
            tick();
        end
        done = 1'b1;
        rd_data = rd;
        @(negedge clk);
        if (wrt) wrts++;
        chk("no_early_cmplt", 16'(cnv_cmplt), 16'h0);
        tick();
        done = 1'b0;
        rd_data = 16'h0000;
        nxt = chain;
        @(negedge clk);
        chk("wrt_pair", 16'(wrts), 16'd2);
        chk("cnv_cmplt", 16'(cnv_cmplt), 16'h1);
        chk("busy_clear", 16'(busy), 16'h0);
        chk("chain_wrt", 16'(wrt), 16'(chain));
        chk("lft_ld", 16'(lft_ld), 16'(el));
        chk("rght_ld", 16'(rght_ld), 16'(er));
        chk("steer_pot", 16'(steer_pot), 16'(es));
        chk("batt", 16'(batt), 16'(eb));
        tick();
        @(negedge clk);
        chk("cmplt_one_pulse", 16'(cnv_cmplt), 16'h0);
        chk("no_wrt_after", 16'(wrt), 16'h0);
        tick();
        if (!chain) nxt = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        nxt     = 1'b0;
        done    = 1'b0;
        rd_data = 16'h0000;
        repeat (2) tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_wrt", 16'(wrt), 16'h0);
        chk("rst_cmd", cmd, 16'h0000);
        chk("rst_lft", 16'(lft_ld), 16'h0);
        chk("rst_rght", 16'(rght_ld), 16'h0);
        chk("rst_steer", 16'(steer_pot), 16'h0);
        chk("rst_batt", 16'(batt), 16'h0);
        chk("rst_cmplt", 16'(cnv_cmplt), 16'h0);
        chk("rst_busy", 16'(busy), 16'h0);
        tick();

        // Single conversion on the left channel
        conv(16'h0ABC, 16'h0000, 12'hABC, 12'h000, 12'h000, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset back to the left channel and clear the holding registers
        rst_n = 1'b0;
        #1;
        chk("rst2_lft", 16'(lft_ld), 16'h0);
        tick();
        rst_n = 1'b1;
        tick();

        tbl[0] = '{16'h0111, 16'h0000, 12'h111, 12'h000, 12'h000, 12'h000, 1'b0};
        tbl[1] = '{16'h0222, 16'h2000, 12'h111, 12'h222, 12'h000, 12'h000, 1'b0};
        tbl[2] = '{16'h0333, 16'h2800, 12'h111, 12'h222, 12'h333, 12'h000, 1'b0};
        tbl[3] = '{16'h0444, 16'h3000, 12'h111, 12'h222, 12'h333, 12'h444, 1'b0};
        tbl[4] = '{16'h0555, 16'h0000, 12'h555, 12'h222, 12'h333, 12'h444, 1'b0};
        tbl[5] = '{16'h0A0B, 16'h2000, 12'h555, 12'hA0B, 12'h333, 12'h444, 1'b1};
        tbl[6] = '{16'h0123, 16'h2800, 12'h555, 12'hA0B, 12'h123, 12'h444, 1'b1};
        tbl[7] = '{16'hF5A5, 16'h3000, 12'h555, 12'hA0B, 12'h123, 12'h5A5, 1'b0};

        for (int i = 0; i < 8; i++) begin
            conv(tbl[i].rd, tbl[i].ecmd, tbl[i].el, tbl[i].er, tbl[i].es, tbl[i].eb,
                 1'b0, 1'b0, 1'b0, tbl[i].spur);
        end

        // nxt held high: one wrt pair per conversion, chained start on cnv_cmplt
        conv(16'h0777, 16'h0000, 12'h777, 12'hA0B, 12'h123, 12'h5A5, 1'b1, 1'b1, 1'b0, 1'b0);
        conv(16'h0888, 16'h2000, 12'h777, 12'h888, 12'h123, 12'h5A5, 1'b1, 1'b0, 1'b1, 1'b0);

        // Reset while waiting for the second done (steer channel in flight)
        nxt = 1'b1;
        @(negedge clk);
        chk("mid_first_wrt", 16'(wrt), 16'h1);
        chk("mid_cmd", cmd, 16'h2800);
        tick();
        nxt = 1'b0;
        repeat (2) tick();
        done = 1'b1;
        rd_data = 16'h0999;
        tick();
        done = 1'b0;
        rd_data = 16'h0000;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_lft", 16'(lft_ld), 16'h0);
        chk("mid_rst_rght", 16'(rght_ld), 16'h0);
        chk("mid_rst_batt", 16'(batt), 16'h0);
        chk("mid_rst_busy", 16'(busy), 16'h0);
        chk("mid_rst_cmd", cmd, 16'h0000);
        chk("mid_rst_wrt", 16'(wrt), 16'h0);
        tick();
        rst_n = 1'b1;
        done = 1'b1;
        rd_data = 16'h0FFF;
        tick();
        done = 1'b0;
        rd_data = 16'h0000;
        @(negedge clk);
        chk("late_done_cmplt", 16'(cnv_cmplt), 16'h0);
        chk("late_done_steer", 16'(steer_pot), 16'h0);
        chk("late_done_busy", 16'(busy), 16'h0);
        tick();

        conv(16'h0321, 16'h0000, 12'h321, 12'h000, 12'h000, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
